timer_scheduler: RTL and testbench

//   Shares one countdown timer among NUM_REQ requesters using round-robin arbitration.
//   A requester asks for a delay of N cycles and receives a one-cycle ack when it is granted.

---
 rtl/timer_sched_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/timer_scheduler.sv | 105 ++++++++++
 tb/tb_timer_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and round-robin search helper for the timer scheduler.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package timer_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    // Upper bound on requesters the search helper can scan.
    localparam int MAX_REQ = 32;

    // Returns the first set req index after 'last', wrapping modulo n.
    // Returns 0 when nothing is set; callers qualify with |req.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int last);
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (last + k) % n;
            if (k <= n && !found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search: first asserted req after 'last', wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [MAX_REQ-1:0] req_ext;

    // Widen req to the helper's fixed width and pick the next winner.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        gnt_valid              = |req;
        gnt_idx                = IDX_W'(rr_pick(req_ext, NUM_REQ, int'(last)));
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one countdown timer among NUM_REQ requesters, round-robin granted.
// Latency: ack one cycle after grant; done C cycles after ack (C = max(cycles,1)).
// Backpressure: requests arriving while the timer runs stay pending until IDLE.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] cycles,
    input  logic [NUM_REQ-1:0]       cancel,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    output logic                     aborted,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner
);

    sched_state_t       state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [NUM_REQ-1:0] ack_q,   ack_d;
    logic [NUM_REQ-1:0] done_q,  done_d;
    logic               aborted_q, aborted_d;

    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]   gnt_cycles;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_cycles = cycles[gnt_idx*WIDTH +: WIDTH];

    // Next-state: grant in IDLE, count down in RUN; completion beats cancel.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d         = RUN;
                    count_d         = (gnt_cycles == '0) ? WIDTH'(1) : gnt_cycles;
                    owner_d         = gnt_idx;
                    last_d          = gnt_idx;
                    ack_d[gnt_idx]  = 1'b1;
                end
            end
            RUN: begin
                if (count_q == WIDTH'(1)) begin
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                end else if (cancel[owner_q]) begin
                    state_d         = IDLE;
                    aborted_d       = 1'b1;
                end else begin
                    count_d         = count_q - WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered output pulses; reset returns everything to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            ack_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign busy    = (state_q == RUN);
    assign owner   = owner_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed stimulus for timer_scheduler with a pulse scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_timer_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        int         cyc;
        logic [3:0] ack;
        logic [3:0] done;
        logic       aborted;
        logic [1:0] owner;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] cycles;
    logic [N-1:0]   cancel;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic           aborted;
    logic           busy;
    logic [1:0]     owner;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    ev_t exp_q[$];
    ev_t mon_e;

    timer_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cycles  (cycles),
        .cancel  (cancel),
        .ack     (ack),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    // Cycle index: outputs seen after posedge k belong to cycle k.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input int a, input int d, input bit ab, input int own);
        ev_t e;
        e.cyc     = c;
        e.ack     = (a >= 0) ? 4'(1 << a) : 4'b0;
        e.done    = (d >= 0) ? 4'(1 << d) : 4'b0;
        e.aborted = ab;
        e.owner   = 2'(own);
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int lim;
        lim = cyc + 60;
        while (exp_q.size() != 0 && cyc < lim) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d pulses still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        cancel = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (|ack || |done || aborted)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: cyc=%0d ack=%b done=%b aborted=%b owner=%0d, expected none",
                         cyc, ack, done, aborted, owner);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || ack !== mon_e.ack || done !== mon_e.done ||
                    aborted !== mon_e.aborted || owner !== mon_e.owner) begin
                    bad++;
                    $display("FAIL pulse: got cyc=%0d ack=%b done=%b ab=%b own=%0d expected cyc=%0d ack=%b done=%b ab=%b own=%0d",
                             cyc, ack, done, aborted, owner,
                             mon_e.cyc, mon_e.ack, mon_e.done, mon_e.aborted, mon_e.owner);
                end
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: bench did not finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        rst    = 1'b1;
        req    = '0;
        cancel = '0;
        cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",     32'(ack),     0);
        check("rst_done",    32'(done),    0);
        check("rst_aborted", 32'(aborted), 0);
        check("rst_busy",    32'(busy),    0);
        check("rst_owner",   32'(owner),   0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single request, 5 cycles
        n = cyc;
        cycles[0*W +: W] = 5;
        req = 4'b0001;
        push(n + 1, 0, -1, 0, 0);
        push(n + 6, -1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_cyc(n + k);
            if (k == 1) req[0] = 1'b0;
            check("t1_busy_run", 32'(busy), 1);
        end
        wait_cyc(n + 6);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_owner", 32'(owner), 0);
        drain();

        // 2: all four request at once, 2 cycles each, fresh pointer
        do_reset();
        n = cyc;
        for (int i = 0; i < N; i++) cycles[i*W +: W] = 2;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            push(n + 1 + 3*i, i, -1, 0, i);
            push(n + 3 + 3*i, -1, i, 0, i);
        end
        for (int i = 0; i < N; i++) begin
            wait_cyc(n + 1 + 3*i);
            req[i] = 1'b0;
        end
        drain();

        // 3: zero delay behaves as one
        n = cyc;
        cycles[2*W +: W] = 0;
        req = 4'b0100;
        push(n + 1, 2, -1, 0, 2);
        push(n + 2, -1, 2, 0, 2);
        wait_cyc(n + 1);
        req = '0;
        drain();

        // 4: owner 1 cancelled mid-run, pending req[0] granted next
        n = cyc;
        cycles[1*W +: W] = 10;
        cycles[0*W +: W] = 3;
        req = 4'b0010;
        push(n + 1, 1, -1, 0, 1);
        push(n + 5, -1, -1, 1, 1);
        push(n + 6, 0, -1, 0, 0);
        push(n + 9, -1, 0, 0, 0);
        wait_cyc(n + 1);
        req[1] = 1'b0;
        wait_cyc(n + 2);
        req[0] = 1'b1;
        wait_cyc(n + 4);
        cancel[1] = 1'b1;
        wait_cyc(n + 5);
        cancel = '0;
        check("t4_busy_after_abort", 32'(busy), 0);
        wait_cyc(n + 6);
        req[0] = 1'b0;
        check("t4_busy_regrant", 32'(busy), 1);
        drain();

        // 5a: cancel on the final count, completion wins
        n = cyc;
        cycles[2*W +: W] = 3;
        req = 4'b0100;
        push(n + 1, 2, -1, 0, 2);
        push(n + 4, -1, 2, 0, 2);
        wait_cyc(n + 1);
        req = '0;
        wait_cyc(n + 3);
        cancel[2] = 1'b1;
        wait_cyc(n + 4);
        cancel = '0;
        drain();

        // 5b: non-owner cancel ignored
        n = cyc;
        cycles[1*W +: W] = 4;
        req = 4'b0010;
        push(n + 1, 1, -1, 0, 1);
        push(n + 5, -1, 1, 0, 1);
        wait_cyc(n + 1);
        req = '0;
        wait_cyc(n + 2);
        cancel[3] = 1'b1;
        wait_cyc(n + 3);
        cancel = '0;
        check("t5_busy_noncancel", 32'(busy), 1);
        drain();

        // 6: async reset mid-run with count at 7
        n = cyc;
        cycles[1*W +: W] = 10;
        req = 4'b0010;
        push(n + 1, 1, -1, 0, 1);
        wait_cyc(n + 1);
        req = '0;
        wait_cyc(n + 4);
        check("t6_owner_pre", 32'(owner), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy",    32'(busy),    0);
        check("t6_rst_owner",   32'(owner),   0);
        check("t6_rst_done",    32'(done),    0);
        check("t6_rst_aborted", 32'(aborted), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = cyc;
        cycles[3*W +: W] = 2;
        req = 4'b1000;
        push(n + 1, 3, -1, 0, 3);
        push(n + 3, -1, 3, 0, 3);
        wait_cyc(n + 1);
        req = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
